// File: rtl/frame_byte_buffer_if.sv
// Bus bundle for frame_byte_buffer: word-write side (encoder) and byte-read side (SPI readout).
// The master drives writes and read requests; the slave (the buffer) returns bytes and frame status.
interface frame_byte_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int WA    = $clog2(DEPTH);
  localparam int BA    = WA + LB;

  // Read handshake: a request is taken in any cycle where read_request_in and
  // read_ready_out are both 1; requests while read_ready_out is 0 are dropped.
  // Every taken request yields exactly one read_valid_out pulse, in order.
  logic                  write_start_in;
  logic                  write_valid_in;
  logic [DATA_WIDTH-1:0] write_data_in;
  logic                  write_last_in;
  logic [LB:0]           write_bytes_in;
  logic                  read_request_in;
  logic [BA-1:0]         read_address_in;
  logic                  read_ready_out;
  logic [7:0]            read_data_out;
  logic                  read_valid_out;
  logic                  frame_ready_out;
  logic [BA:0]           frame_bytes_out;
  logic                  overflow_out;
  logic                  read_state_out;

  modport master (
    output write_start_in, write_valid_in, write_data_in, write_last_in, write_bytes_in,
    output read_request_in, read_address_in,
    input  read_ready_out, read_data_out, read_valid_out,
    input  frame_ready_out, frame_bytes_out, overflow_out, read_state_out
  );

  modport slave (
    input  write_start_in, write_valid_in, write_data_in, write_last_in, write_bytes_in,
    input  read_request_in, read_address_in,
    output read_ready_out, read_data_out, read_valid_out,
    output frame_ready_out, frame_bytes_out, overflow_out, read_state_out
  );
endinterface

// File: rtl/frame_byte_buffer.sv
// Single-port word RAM holding one compressed frame; words written at an auto-incrementing
// pointer, bytes read back with a two-cycle registered path. Writes own the port; reads wait.
module frame_byte_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384
) (
  input  logic                clock_in,
  input  logic                reset_n_in,
  frame_byte_buffer_if.slave  bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int LBW   = (LB == 0) ? 1 : LB;
  localparam int WA    = $clog2(DEPTH);
  localparam int BA    = WA + LB;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [BA:0] FULL_BYTES = (BA+1)'(DEPTH * BYTES);
  localparam logic [WA:0] WP_ONE     = (WA+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_ram_q;

  logic [WA:0]   r_wp;
  logic          r_frame_ready;
  logic [BA:0]   r_frame_bytes;
  logic          r_overflow;

  logic [0:0]    r_state;
  logic [BA-1:0] r_pend_addr;

  logic          r_s1_valid;
  logic          r_s1_oof;
  logic [LBW-1:0] r_s1_lane;
  logic          r_valid;
  logic [7:0]    r_data;

  logic          w_fr_eff;
  logic [WA:0]   w_wp_eff;
  logic          w_wr_open;
  logic          w_wr_accept;
  logic          w_wr_drop;
  logic          w_port_free;
  logic          w_req_accept;
  logic          w_issue;
  logic [BA-1:0] w_rd_addr;
  logic [WA-1:0] w_rd_word;
  logic [LBW-1:0] w_rd_lane;
  logic          w_rd_oof;
  logic [BA:0]   w_last_bytes;
  logic [BA:0]   w_wr_base;
  logic [BA:0]   w_accept_bytes;
  logic [7:0]    w_lane_byte;

  // A start in the same cycle as a write is seen first: the write lands at word 0 of a fresh frame.
  assign w_fr_eff    = bus.write_start_in ? 1'b0 : r_frame_ready;
  assign w_wp_eff    = bus.write_start_in ? '0   : r_wp;
  assign w_wr_open   = bus.write_valid_in && !w_fr_eff;
  assign w_wr_accept = w_wr_open && !w_wp_eff[WA];
  assign w_wr_drop   = w_wr_open &&  w_wp_eff[WA];
  assign w_port_free = !w_wr_open;

  assign w_req_accept = bus.read_request_in && (r_state == ST_IDLE);
  assign w_issue      = w_port_free && ((r_state == ST_PEND) || w_req_accept);
  assign w_rd_addr    = (r_state == ST_PEND) ? r_pend_addr : bus.read_address_in;
  assign w_rd_word    = w_rd_addr[BA-1:LB];
  assign w_rd_lane    = LBW'(w_rd_addr) & LBW'(BYTES - 1);
  assign w_rd_oof     = r_frame_ready && ({1'b0, w_rd_addr} >= r_frame_bytes);

  assign w_last_bytes   = (bus.write_bytes_in == '0) ? (BA+1)'(BYTES) : (BA+1)'(bus.write_bytes_in);
  assign w_wr_base      = (BA+1)'(w_wp_eff) << LB;
  assign w_accept_bytes = w_wr_base + w_last_bytes;

  assign w_lane_byte = r_ram_q[r_s1_lane*8 +: 8];

  // Storage keeps its contents across reset and frame starts; no reset on purpose.
  always_ff @(posedge clock_in) begin
    if (w_wr_accept) begin
      r_mem[w_wp_eff[WA-1:0]] <= bus.write_data_in;
    end else if (w_issue) begin
      r_ram_q <= r_mem[w_rd_word];
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_wp          <= '0;
      r_frame_ready <= 1'b0;
      r_frame_bytes <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wp       <= w_wr_accept ? (w_wp_eff + WP_ONE) : w_wp_eff;
      r_overflow <= w_wr_drop ? 1'b1 : (bus.write_start_in ? 1'b0 : r_overflow);
      if (bus.write_last_in && w_wr_accept) begin
        r_frame_ready <= 1'b1;
        r_frame_bytes <= w_accept_bytes;
      end else if (bus.write_last_in && w_wr_drop) begin
        r_frame_ready <= 1'b1;
        r_frame_bytes <= FULL_BYTES;
      end else if (bus.write_start_in) begin
        r_frame_ready <= 1'b0;
        r_frame_bytes <= '0;
      end
    end
  end

  // Read arbiter: a request that loses the port to a write parks here until the port frees up.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= ST_IDLE;
      r_pend_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_accept && !w_port_free) begin
            r_state     <= ST_PEND;
            r_pend_addr <= bus.read_address_in;
          end
        end
        ST_PEND: begin
          if (w_port_free) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Lane and out-of-frame decision travel with the RAM read so the byte mux sees matching data.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_s1_valid <= 1'b0;
      r_s1_oof   <= 1'b0;
      r_s1_lane  <= '0;
      r_valid    <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      r_s1_valid <= w_issue;
      if (w_issue) begin
        r_s1_lane <= w_rd_lane;
        r_s1_oof  <= w_rd_oof;
      end
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data <= r_s1_oof ? 8'h00 : w_lane_byte;
      end
    end
  end

  assign bus.read_ready_out  = (r_state == ST_IDLE);
  assign bus.read_state_out  = r_state[0];
  assign bus.read_data_out   = r_data;
  assign bus.read_valid_out  = r_valid;
  assign bus.frame_ready_out = r_frame_ready;
  assign bus.frame_bytes_out = r_frame_bytes;
  assign bus.overflow_out    = r_overflow;
endmodule

// File: tb/tb_frame_byte_buffer.sv
// Directed bench for frame_byte_buffer: a 32-bit/16-word instance and a 64-bit/8-word instance,
// with expected read bytes and their arrival cycles queued by the drivers and checked by a monitor.
module tb_frame_byte_buffer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  frame_byte_buffer_if #(.DATA_WIDTH(32), .DEPTH(16)) bus_a ();
  frame_byte_buffer_if #(.DATA_WIDTH(64), .DEPTH(8))  bus_b ();

  frame_byte_buffer #(.DATA_WIDTH(32), .DEPTH(16)) dut_a (
    .clock_in(clk), .reset_n_in(rst_n), .bus(bus_a)
  );
  frame_byte_buffer #(.DATA_WIDTH(64), .DEPTH(8)) dut_b (
    .clock_in(clk), .reset_n_in(rst_n), .bus(bus_b)
  );

  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int         cyc_a_q[$];
  int         cyc_b_q[$];

  logic [31:0] a_words[3];
  logic [63:0] b_words[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every read_valid_out pulse must match the oldest queued byte and its due cycle.
  logic [7:0] mon_e;
  int         mon_c;
  always @(negedge clk) begin
    if (bus_a.read_valid_out === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_valid: got valid with data 0x%0h at cycle %0d, expected none", bus_a.read_data_out, cyc);
      end else begin
        mon_e = exp_a_q.pop_front();
        mon_c = cyc_a_q.pop_front();
        chk("a_rd_data", 64'(bus_a.read_data_out), 64'(mon_e));
        chk("a_rd_cycle", 64'(cyc), 64'(mon_c));
      end
    end
    if (bus_b.read_valid_out === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_valid: got valid with data 0x%0h at cycle %0d, expected none", bus_b.read_data_out, cyc);
      end else begin
        mon_e = exp_b_q.pop_front();
        mon_c = cyc_b_q.pop_front();
        chk("b_rd_data", 64'(bus_b.read_data_out), 64'(mon_e));
        chk("b_rd_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.write_start_in  = 1'b0;
    bus_a.write_valid_in  = 1'b0;
    bus_a.write_data_in   = '0;
    bus_a.write_last_in   = 1'b0;
    bus_a.write_bytes_in  = '0;
    bus_a.read_request_in = 1'b0;
    bus_a.read_address_in = '0;
  endtask

  task automatic idle_b();
    bus_b.write_start_in  = 1'b0;
    bus_b.write_valid_in  = 1'b0;
    bus_b.write_data_in   = '0;
    bus_b.write_last_in   = 1'b0;
    bus_b.write_bytes_in  = '0;
    bus_b.read_request_in = 1'b0;
    bus_b.read_address_in = '0;
  endtask

  task automatic wr_a(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bus_a.write_valid_in = 1'b1;
    bus_a.write_data_in  = d;
    bus_a.write_last_in  = last;
    bus_a.write_bytes_in = nb;
  endtask

  task automatic wr_a_off();
    bus_a.write_valid_in = 1'b0;
    bus_a.write_last_in  = 1'b0;
    bus_a.write_bytes_in = '0;
  endtask

  task automatic wr_b(input logic [63:0] d, input logic last, input logic [3:0] nb);
    bus_b.write_valid_in = 1'b1;
    bus_b.write_data_in  = d;
    bus_b.write_last_in  = last;
    bus_b.write_bytes_in = nb;
  endtask

  task automatic rd_a(input logic [5:0] addr, input logic [7:0] e, input int lat);
    bus_a.read_request_in = 1'b1;
    bus_a.read_address_in = addr;
    exp_a_q.push_back(e);
    cyc_a_q.push_back(cyc + lat);
  endtask

  task automatic rd_b(input logic [5:0] addr, input logic [7:0] e, input int lat);
    bus_b.read_request_in = 1'b1;
    bus_b.read_address_in = addr;
    exp_b_q.push_back(e);
    cyc_b_q.push_back(cyc + lat);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ready"},  64'(bus_a.read_ready_out),  64'd1);
    chk({tag, "_data"},   64'(bus_a.read_data_out),   64'h00);
    chk({tag, "_valid"},  64'(bus_a.read_valid_out),  64'd0);
    chk({tag, "_fready"}, 64'(bus_a.frame_ready_out), 64'd0);
    chk({tag, "_fbytes"}, 64'(bus_a.frame_bytes_out), 64'd0);
    chk({tag, "_ovf"},    64'(bus_a.overflow_out),    64'd0);
  endtask

  initial begin
    logic [7:0] e8;
    int guard;
    a_words[0] = 32'h44332211;
    a_words[1] = 32'h88776655;
    a_words[2] = 32'hCCBBAA99;
    b_words[0] = 64'h8877665544332211;
    b_words[1] = 64'h1F1E1D1C1B1A1918;
    idle_a();
    idle_b();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("rst_a");
    chk("rst_b_ready",  64'(bus_b.read_ready_out),  64'd1);
    chk("rst_b_fbytes", 64'(bus_b.frame_bytes_out), 64'd0);
    rst_n = 1'b1;
    step();

    // Three-word frame, last word carries 2 bytes -> 10-byte frame.
    bus_a.write_start_in = 1'b1;
    step();
    bus_a.write_start_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_a(a_words[k], (k == 2), 3'd2);
      step();
    end
    wr_a_off();
    chk("t1_fready", 64'(bus_a.frame_ready_out), 64'd1);
    chk("t1_fbytes", 64'(bus_a.frame_bytes_out), 64'd10);
    chk("t1_ovf",    64'(bus_a.overflow_out),    64'd0);
    for (int i = 0; i < 12; i++) begin
      e8 = (i < 10) ? a_words[i / 4][8 * (i % 4) +: 8] : 8'h00;
      rd_a(6'(i), e8, 2);
      step();
    end
    bus_a.read_request_in = 1'b0;

    // A write after the frame closed is ignored and does not raise overflow.
    wr_a(32'h12345678, 1'b1, 3'd1);
    step();
    wr_a_off();
    chk("t1_ign_fbytes", 64'(bus_a.frame_bytes_out), 64'd10);
    chk("t1_ign_fready", 64'(bus_a.frame_ready_out), 64'd1);
    chk("t1_ign_ovf",    64'(bus_a.overflow_out),    64'd0);
    repeat (3) step();

    // Read colliding with a 4-word burst: held, issued after the burst, valid 6 cycles after request.
    bus_a.write_start_in = 1'b1;
    step();
    bus_a.write_start_in = 1'b0;
    wr_a(32'h03020100, 1'b0, 3'd0);
    rd_a(6'd13, 8'h0D, 6);
    step();
    bus_a.read_request_in = 1'b0;
    wr_a(32'h07060504, 1'b0, 3'd0);
    chk("t2_ready_c1", 64'(bus_a.read_ready_out), 64'd0);
    step();
    wr_a(32'h0B0A0908, 1'b0, 3'd0);
    bus_a.read_request_in = 1'b1;
    bus_a.read_address_in = 6'd0;
    chk("t2_ready_c2", 64'(bus_a.read_ready_out), 64'd0);
    step();
    wr_a(32'h0F0E0D0C, 1'b0, 3'd0);
    bus_a.read_request_in = 1'b0;
    chk("t2_ready_c3", 64'(bus_a.read_ready_out), 64'd0);
    step();
    wr_a_off();
    chk("t2_ready_c4", 64'(bus_a.read_ready_out), 64'd0);
    step();
    chk("t2_ready_c5", 64'(bus_a.read_ready_out), 64'd1);
    chk("t2_fready",   64'(bus_a.frame_ready_out), 64'd0);
    repeat (3) step();

    // 17 writes into 16 words, last on the 17th.
    bus_a.write_start_in = 1'b1;
    step();
    bus_a.write_start_in = 1'b0;
    for (int k = 0; k < 17; k++) begin
      wr_a({8'hC0 + 8'(k), 8'hB0, 8'hA0, 8'h10 + 8'(k)}, (k == 16), 3'd0);
      if (k == 16) begin
        chk("t3_ovf_at16",    64'(bus_a.overflow_out),    64'd0);
        chk("t3_fready_at16", 64'(bus_a.frame_ready_out), 64'd0);
      end
      step();
    end
    wr_a_off();
    chk("t3_ovf",    64'(bus_a.overflow_out),    64'd1);
    chk("t3_fready", 64'(bus_a.frame_ready_out), 64'd1);
    chk("t3_fbytes", 64'(bus_a.frame_bytes_out), 64'd64);
    rd_a(6'd0, 8'h10, 2);
    step();
    rd_a(6'd3, 8'hC0, 2);
    step();
    rd_a(6'd63, 8'hCF, 2);
    step();
    bus_a.read_request_in = 1'b0;

    // Ignored write, then start together with a write of 0xDEADBEEF.
    wr_a(32'h55555555, 1'b1, 3'd1);
    step();
    wr_a_off();
    chk("t4_ign_fbytes", 64'(bus_a.frame_bytes_out), 64'd64);
    chk("t4_ign_fready", 64'(bus_a.frame_ready_out), 64'd1);
    chk("t4_ign_ovf",    64'(bus_a.overflow_out),    64'd1);
    bus_a.write_start_in = 1'b1;
    wr_a(32'hDEADBEEF, 1'b0, 3'd0);
    step();
    bus_a.write_start_in = 1'b0;
    wr_a_off();
    chk("t4_fready", 64'(bus_a.frame_ready_out), 64'd0);
    chk("t4_ovf",    64'(bus_a.overflow_out),    64'd0);
    chk("t4_fbytes", 64'(bus_a.frame_bytes_out), 64'd0);
    rd_a(6'd0, 8'hEF, 2);
    step();
    rd_a(6'd3, 8'hDE, 2);
    step();
    rd_a(6'd4, 8'h11, 2);
    step();
    bus_a.read_request_in = 1'b0;
    repeat (3) step();

    // Reset while a read is parked behind writes in a half-written frame.
    wr_a(32'h01010101, 1'b0, 3'd0);
    bus_a.read_request_in = 1'b1;
    bus_a.read_address_in = 6'd1;
    step();
    bus_a.read_request_in = 1'b0;
    wr_a(32'h02020202, 1'b0, 3'd0);
    chk("t5_pending", 64'(bus_a.read_ready_out), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_a("t5_rst");
    idle_a();
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    rd_a(6'd0, 8'hEF, 2);
    step();
    bus_a.read_request_in = 1'b0;

    // 64-bit instance: two words, last with bytes=0 meaning all 8; 16 back-to-back reads.
    bus_b.write_start_in = 1'b1;
    step();
    bus_b.write_start_in = 1'b0;
    wr_b(b_words[0], 1'b0, 4'd0);
    step();
    wr_b(b_words[1], 1'b1, 4'd0);
    step();
    idle_b();
    chk("t6_fready", 64'(bus_b.frame_ready_out), 64'd1);
    chk("t6_fbytes", 64'(bus_b.frame_bytes_out), 64'd16);
    for (int i = 0; i < 16; i++) begin
      e8 = b_words[i / 8][8 * (i % 8) +: 8];
      rd_b(6'(i), e8, 2);
      step();
    end
    bus_b.read_request_in = 1'b0;

    guard = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && guard < 50) begin
      step();
      guard++;
    end
    repeat (4) step();
    chk("drain_a_left", 64'(exp_a_q.size()), 64'd0);
    chk("drain_b_left", 64'(exp_b_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_byte_buffer.md
# frame_byte_buffer

Parametrised, single-clock frame buffer for compressed camera output. It sits between the JPEG encoder output and the SPI readout path, downstream of the clock-domain crossing. Whole words are written at an auto-incrementing address, and a frame length in bytes is tracked. The SPI side reads the frame back one byte at a time with a valid handshake. Writes take priority; a read that collides with a write is held, not lost. Overflow and out-of-frame reads are handled explicitly.

## Interface
- DATA_WIDTH, 32: write word width in bits; multiple of 8, 8..128; BYTES = DATA_WIDTH/8.
- DEPTH, 16384: words of storage; power of 2; WA = log2(DEPTH), BA = WA + log2(BYTES).
- clock_in  input  1  single clock for the whole block; all logic is on its rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- write_start_in  input  1  pulse: new frame; write pointer to 0; clears frame_ready_out, frame_bytes_out, overflow_out.
- write_valid_in  input  1  write_data_in is valid this cycle; no backpressure.
- write_data_in  input  DATA_WIDTH  word; byte lane k = bits[8k+7:8k]; lane 0 = lowest byte address.
- write_last_in  input  1  qualifies write_valid_in: final word of the frame.
- write_bytes_in  input  log2(BYTES)+1  valid bytes in the last word, 1..BYTES; 0 means BYTES; ignored unless write_last_in.
- read_request_in  input  1  byte read request; accepted when read_ready_out is 1.
- read_address_in  input  BA  byte address.
- read_ready_out  output  1  no read pending.
- read_data_out  output  8  returned byte.
- read_valid_out  output  1  one-cycle pulse, read_data_out valid.
- frame_ready_out  output  1  last word written; frame length final.
- frame_bytes_out  output  BA+1  frame length in bytes.
- overflow_out  output  1  sticky: at least one word dropped because the buffer was full.

## Operation
- Storage is a single-port, DEPTH x DATA_WIDTH RAM with a registered read. Contents are not cleared by reset or by write_start_in.
- Write pointer wp has WA+1 bits.
  - A write is accepted when write_valid_in=1, wp<DEPTH and frame_ready_out=0.
  - An accepted write stores the word at wp, then wp increments.
- write_start_in in the same cycle as write_valid_in: the start applies first, so the word goes to address 0.
- Overflow: write_valid_in with wp==DEPTH and frame_ready_out=0. The word is dropped, overflow_out is set, wp stays at DEPTH.
- Last word, accepted: frame_bytes_out = wp*BYTES + (write_bytes_in==0 ? BYTES : write_bytes_in), and frame_ready_out=1.
- Last word, dropped by overflow: frame_bytes_out = DEPTH*BYTES, and frame_ready_out=1.
- Once frame_ready_out=1, writes are silently ignored until write_start_in. overflow_out is not set by these ignored writes.
- Read arbitration: the RAM port is free in any cycle without an accepted or overflowing write.
  - An accepted request whose port is free issues immediately.
  - Otherwise the request is captured in a one-entry pending register, and read_ready_out=0 from the next cycle.
  - The pending read issues on the first free cycle; read_ready_out returns to 1 the cycle after it issues.
  - Requests made while read_ready_out=0 are ignored.
- RAM read address is read_address_in[BA-1:log2(BYTES)]. Lane select is read_address_in[log2(BYTES)-1:0], pipelined alongside the RAM read.
- Out-of-frame read: if frame_ready_out=1 at issue and address >= frame_bytes_out, the returned byte is 0x00. Before frame_ready_out, reads return raw RAM contents.
- Sustained throughput: one read per cycle while no writes occur.

## Timing
- Reset values: read_ready_out=1; read_data_out=0x00; read_valid_out=0; frame_ready_out=0; frame_bytes_out=0; overflow_out=0. wp=0; pending read discarded; read pipeline flushed.
- Write: the RAM is updated at the edge ending the accept cycle. A read issued in the next cycle returns the new data.
- frame_ready_out and frame_bytes_out update at the edge ending the last-write cycle.
- Read latency: issue cycle T gives read_valid_out=1 with data in cycle T+2. read_data_out holds its value until the next valid.
- Collision: a request in cycle T with a write in T, and no write in T+1, gives read_valid_out at T+3.
- write_start_in does not affect reads in flight.
- reset_n_in asserted mid-read: read_valid_out is never pulsed for that read.

## Test plan
- DATA_WIDTH=32, DEPTH=16: write 3 words 0x44332211, 0x88776655, 0xCCBBAA99 with last and write_bytes_in=2 -> frame_bytes_out=10, frame_ready_out=1; reads of bytes 0..9 return 0x11..0xAA in order; byte 10 and byte 11 return 0x00; each with valid exactly 2 cycles after request.
- Read request in the same cycle as a write, then a 4-cycle write burst -> read_ready_out=0 during the burst; data is returned 2 cycles after the burst ends; no lost or duplicated valid.
- 17 writes into DEPTH=16, last on the 17th -> overflow_out=1; frame_bytes_out=64; word 0 intact.
- Write after frame_ready_out, then write_start_in together with write_valid_in=0xDEADBEEF -> the ignored write changes nothing; after start, byte 0 reads 0xEF; frame_ready_out=0, overflow_out=0.
- reset_n_in pulsed while a read is pending and the frame is half-written -> all outputs at reset values immediately; no read_valid_out follows.
- DATA_WIDTH=64, DEPTH=8: back-to-back reads of bytes 0..15, one per cycle -> 16 consecutive valids with correct little-endian lanes.
